// File: rtl/mem_access.sv
// MIPS memory-access stage: drives loads/stores onto a req/ack data bus and registers the MEM/WB result.
// Optional DBUS_TIMEOUT_EN macro: abort a bus request after TIMEOUT_CYCLES un-acked REQ cycles.
module mem_access #(
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  mem_wd,
   input  logic [31:0] mem_wdata,
   input  logic        mem_wreg,
   input  logic [3:0]  mem_op,
   input  logic [31:0] mem_addr,
   input  logic [31:0] mem_sdata,
   output logic        dbus_req,
   output logic        dbus_we,
   output logic [31:0] dbus_addr,
   output logic [3:0]  dbus_sel,
   output logic [31:0] dbus_wdata,
   input  logic [31:0] dbus_rdata,
   input  logic        dbus_ack,
   output logic [4:0]  wb_wd,
   output logic [31:0] wb_wdata,
   output logic        wb_wreg,
   output logic        stall_req,
   output logic        mem_misalign,
   output logic        dbus_timeout
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;

   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] TO_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
`ifdef DBUS_TIMEOUT_EN
   localparam logic TO_EN = 1'b1;
`else
   localparam logic TO_EN = 1'b0;
`endif

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_stall;
   logic              w_ack_hit;
   logic              w_to_hit;
   logic              w_mem_access;
   logic              w_misalign;
   logic [1:0]        w_lane;

   logic              r_dbus_req;
   logic              r_dbus_we;
   logic [31:0]       r_dbus_addr;
   logic [3:0]        r_dbus_sel;
   logic [31:0]       r_dbus_wdata;
   logic [4:0]        r_wb_wd;
   logic [31:0]       r_wb_wdata;
   logic              r_wb_wreg;
   logic              r_misalign;
   logic              r_timeout;
   logic              r_abort;
   logic [31:0]       r_rdata;
   logic [3:0]        r_op;
   logic [1:0]        r_lane;
   logic [CNT_W-1:0]  r_cnt;

   function automatic logic f_is_mem(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_SW);
   endfunction

   function automatic logic f_is_store(input logic [3:0] op);
      return (op >= OP_SB) && (op <= OP_SW);
   endfunction

   function automatic logic f_is_load(input logic [3:0] op);
      return (op >= OP_LB) && (op <= OP_LW);
   endfunction

   function automatic logic f_misaligned(input logic [3:0] op, input logic [1:0] lane);
      case (op)
         OP_LH, OP_LHU, OP_SH: return lane[0];
         OP_LW, OP_SW:         return (lane != 2'b00);
         default:              return 1'b0;
      endcase
   endfunction

   // Big-endian lanes: byte offset 0 lives in bits 31:24.
   function automatic logic [3:0] f_lane_sel(input logic [3:0] op, input logic [1:0] lane);
      case (op)
         OP_LB, OP_LBU, OP_SB: return 4'b1000 >> lane;
         OP_LH, OP_LHU, OP_SH: return lane[1] ? 4'b0011 : 4'b1100;
         OP_LW, OP_SW:         return 4'b1111;
         default:              return 4'b0000;
      endcase
   endfunction

   function automatic logic [31:0] f_store_data(input logic [3:0] op, input logic [31:0] sdata);
      case (op)
         OP_SB:   return {4{sdata[7:0]}};
         OP_SH:   return {2{sdata[15:0]}};
         OP_SW:   return sdata;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] f_load_ext(input logic [3:0] op, input logic [1:0] lane,
                                              input logic [31:0] rdata);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = rdata[31:24];
         2'd1:    b = rdata[23:16];
         2'd2:    b = rdata[15:8];
         default: b = rdata[7:0];
      endcase
      h = lane[1] ? rdata[15:0] : rdata[31:16];
      case (op)
         OP_LB:   return {{24{b[7]}}, b};
         OP_LBU:  return {24'd0, b};
         OP_LH:   return {{16{h[15]}}, h};
         OP_LHU:  return {16'd0, h};
         OP_LW:   return rdata;
         default: return 32'd0;
      endcase
   endfunction

   assign w_lane       = mem_addr[1:0];
   assign w_mem_access = f_is_mem(mem_op) & ~f_misaligned(mem_op, w_lane);
   assign w_misalign   = f_is_mem(mem_op) &  f_misaligned(mem_op, w_lane);

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM next state and stall request
   always_comb begin
      w_state_nxt = r_state;
      w_stall     = 1'b0;
      w_ack_hit   = 1'b0;
      w_to_hit    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_mem_access) begin
               w_state_nxt = S_REQ;
               w_stall     = 1'b1;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_REQ: begin
            w_stall = 1'b1;
            if (dbus_ack) begin
               w_ack_hit   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (TO_EN && (r_cnt == TO_LIMIT)) begin
               w_to_hit    = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_state_nxt = S_REQ;
            end
         end
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Bus, writeback and status registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_dbus_req   <= 1'b0;
         r_dbus_we    <= 1'b0;
         r_dbus_addr  <= 32'd0;
         r_dbus_sel   <= 4'd0;
         r_dbus_wdata <= 32'd0;
         r_wb_wd      <= 5'd0;
         r_wb_wdata   <= 32'd0;
         r_wb_wreg    <= 1'b0;
         r_misalign   <= 1'b0;
         r_timeout    <= 1'b0;
         r_abort      <= 1'b0;
         r_rdata      <= 32'd0;
         r_op         <= 4'd0;
         r_lane       <= 2'd0;
         r_cnt        <= '0;
      end else begin
         r_misalign <= 1'b0;
         r_timeout  <= 1'b0;
         case (r_state)
            S_IDLE: begin
               r_abort <= 1'b0;
               r_cnt   <= '0;
               if (w_mem_access) begin
                  r_dbus_req   <= 1'b1;
                  r_dbus_we    <= f_is_store(mem_op);
                  r_dbus_addr  <= {mem_addr[31:2], 2'b00};
                  r_dbus_sel   <= f_lane_sel(mem_op, w_lane);
                  r_dbus_wdata <= f_store_data(mem_op, mem_sdata);
                  r_op         <= mem_op;
                  r_lane       <= w_lane;
                  r_wb_wd      <= 5'd0;
                  r_wb_wdata   <= 32'd0;
                  r_wb_wreg    <= 1'b0;
               end else if (w_misalign) begin
                  r_misalign <= 1'b1;
                  r_wb_wd    <= 5'd0;
                  r_wb_wdata <= 32'd0;
                  r_wb_wreg  <= 1'b0;
               end else begin
                  r_wb_wd    <= mem_wd;
                  r_wb_wdata <= mem_wdata;
                  r_wb_wreg  <= mem_wreg;
               end
            end
            S_REQ: begin
               r_wb_wd    <= 5'd0;
               r_wb_wdata <= 32'd0;
               r_wb_wreg  <= 1'b0;
               if (w_ack_hit) begin
                  r_rdata    <= dbus_rdata;
                  r_dbus_req <= 1'b0;
               end else if (w_to_hit) begin
                  r_dbus_req <= 1'b0;
                  r_timeout  <= 1'b1;
                  r_abort    <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_DONE: begin
               // Upstream still holds the op here; this edge is where the pipeline advances.
               if (f_is_load(r_op) && !r_abort) begin
                  r_wb_wd    <= mem_wd;
                  r_wb_wdata <= f_load_ext(r_op, r_lane, r_rdata);
                  r_wb_wreg  <= mem_wreg;
               end else begin
                  r_wb_wd    <= 5'd0;
                  r_wb_wdata <= 32'd0;
                  r_wb_wreg  <= 1'b0;
               end
            end
            default: begin
               r_dbus_req <= 1'b0;
               r_wb_wd    <= 5'd0;
               r_wb_wdata <= 32'd0;
               r_wb_wreg  <= 1'b0;
            end
         endcase
      end
   end

   assign dbus_req     = r_dbus_req;
   assign dbus_we      = r_dbus_we;
   assign dbus_addr    = r_dbus_addr;
   assign dbus_sel     = r_dbus_sel;
   assign dbus_wdata   = r_dbus_wdata;
   assign wb_wd        = r_wb_wd;
   assign wb_wdata     = r_wb_wdata;
   assign wb_wreg      = r_wb_wreg;
   assign mem_misalign = r_misalign;
   assign dbus_timeout = r_timeout;
   // No stall while reset is held, even if upstream still presents a memory op.
   assign stall_req    = w_stall & ~rst;

endmodule

// File: tb/tb_mem_access.sv
// Directed self-checking bench for mem_access with hand-computed expectations.
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic [4:0]  mem_wd;
   logic [31:0] mem_wdata;
   logic        mem_wreg;
   logic [3:0]  mem_op;
   logic [31:0] mem_addr;
   logic [31:0] mem_sdata;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_wdata;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;
   logic [4:0]  wb_wd;
   logic [31:0] wb_wdata;
   logic        wb_wreg;
   logic        stall_req;
   logic        mem_misalign;
   logic        dbus_timeout;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mem_access #(.TIMEOUT_CYCLES(4)) dut (
      .clk(clk), .rst(rst),
      .mem_wd(mem_wd), .mem_wdata(mem_wdata), .mem_wreg(mem_wreg),
      .mem_op(mem_op), .mem_addr(mem_addr), .mem_sdata(mem_sdata),
      .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
      .dbus_sel(dbus_sel), .dbus_wdata(dbus_wdata), .dbus_rdata(dbus_rdata),
      .dbus_ack(dbus_ack),
      .wb_wd(wb_wd), .wb_wdata(wb_wdata), .wb_wreg(wb_wreg),
      .stall_req(stall_req), .mem_misalign(mem_misalign), .dbus_timeout(dbus_timeout)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      mem_op = 4'd0; mem_wd = 5'd0; mem_wdata = 32'd0; mem_wreg = 1'b0;
      mem_addr = 32'd0; mem_sdata = 32'd0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
   endtask

   task automatic present(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                          input logic [4:0] wd, input logic [31:0] wdata, input logic wreg);
      mem_op = op; mem_addr = addr; mem_sdata = sdata;
      mem_wd = wd; mem_wdata = wdata; mem_wreg = wreg; dbus_ack = 1'b0;
   endtask

   // Full bus transaction; returns just after the DONE edge so the caller checks wb_*.
   task automatic run_mem(input string tag, input logic [3:0] op, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [31:0] rdata, input int ack_wait,
                          input logic [3:0] exp_sel, input logic exp_we, input logic [31:0] exp_bw);
      present(op, addr, sdata, 5'd7, 32'hDEAD_BEEF, 1'b1);
      #1;
      check({tag, ".stall_detect"}, stall_req, 32'd1);
      tick();
      check({tag, ".req"}, dbus_req, 32'd1);
      check({tag, ".we"}, dbus_we, exp_we);
      check({tag, ".addr"}, dbus_addr, addr & 32'hFFFF_FFFC);
      check({tag, ".sel"}, dbus_sel, exp_sel);
      if (exp_we) check({tag, ".wdata"}, dbus_wdata, exp_bw);
      check({tag, ".wb_bubble"}, wb_wreg, 32'd0);
      for (int i = 0; i < ack_wait; i++) begin
         tick();
         check({tag, ".req_hold"}, dbus_req, 32'd1);
         check({tag, ".stall_hold"}, stall_req, 32'd1);
      end
      dbus_ack = 1'b1; dbus_rdata = rdata;
      tick();
      dbus_ack = 1'b0; dbus_rdata = 32'd0;
      check({tag, ".req_drop"}, dbus_req, 32'd0);
      check({tag, ".stall_done"}, stall_req, 32'd0);
      tick();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      rst = 1'b1;
      set_idle();
      tick(); tick();
      check("rst.req", dbus_req, 32'd0);
      check("rst.wb_wreg", wb_wreg, 32'd0);
      check("rst.wb_wdata", wb_wdata, 32'd0);
      check("rst.wb_wd", wb_wd, 32'd0);
      check("rst.stall", stall_req, 32'd0);
      check("rst.misalign", mem_misalign, 32'd0);
      check("rst.timeout", dbus_timeout, 32'd0);
      rst = 1'b0;

      // ALU result passes through with one cycle latency
      present(4'd0, 32'd0, 32'd0, 5'd5, 32'h0000_1234, 1'b1);
      #1 check("add.stall", stall_req, 32'd0);
      tick();
      check("add.wb_wd", wb_wd, 32'd5);
      check("add.wb_wdata", wb_wdata, 32'h0000_1234);
      check("add.wb_wreg", wb_wreg, 32'd1);
      check("add.stall_after", stall_req, 32'd0);
      set_idle();

      run_mem("lb", 4'd1, 32'h103, 32'd0, 32'h0000_00F0, 2, 4'b0001, 1'b0, 32'd0);
      check("lb.wb_wdata", wb_wdata, 32'hFFFF_FFF0);
      check("lb.wb_wreg", wb_wreg, 32'd1);
      check("lb.wb_wd", wb_wd, 32'd7);
      set_idle();

      run_mem("lbu", 4'd2, 32'h103, 32'd0, 32'h0000_00F0, 2, 4'b0001, 1'b0, 32'd0);
      check("lbu.wb_wdata", wb_wdata, 32'h0000_00F0);
      set_idle();

      run_mem("lh", 4'd3, 32'h102, 32'd0, 32'h0000_8001, 1, 4'b0011, 1'b0, 32'd0);
      check("lh.wb_wdata", wb_wdata, 32'hFFFF_8001);
      set_idle();

      run_mem("lhu", 4'd4, 32'h100, 32'd0, 32'h8001_0000, 0, 4'b1100, 1'b0, 32'd0);
      check("lhu.wb_wdata", wb_wdata, 32'h0000_8001);
      set_idle();

      run_mem("lw", 4'd5, 32'h10, 32'd0, 32'h1234_5678, 0, 4'b1111, 1'b0, 32'd0);
      check("lw.wb_wdata", wb_wdata, 32'h1234_5678);
      check("lw.wb_wreg", wb_wreg, 32'd1);
      set_idle();

      run_mem("sh", 4'd7, 32'h202, 32'h0000_ABCD, 32'h1111_1111, 1, 4'b0011, 1'b1, 32'hABCD_ABCD);
      check("sh.wb_wreg", wb_wreg, 32'd0);
      set_idle();

      run_mem("sb", 4'd6, 32'h301, 32'h0000_005A, 32'd0, 0, 4'b0100, 1'b1, 32'h5A5A_5A5A);
      check("sb.wb_wreg", wb_wreg, 32'd0);
      set_idle();

      run_mem("sw", 4'd8, 32'h20, 32'hCAFE_F00D, 32'd0, 3, 4'b1111, 1'b1, 32'hCAFE_F00D);
      check("sw.wb_wreg", wb_wreg, 32'd0);
      set_idle();

      // Misaligned word and halfword: no bus cycle, single pulse
      present(4'd5, 32'h5, 32'd0, 5'd4, 32'h9999_9999, 1'b1);
      #1 check("mis_lw.stall", stall_req, 32'd0);
      tick();
      check("mis_lw.pulse", mem_misalign, 32'd1);
      check("mis_lw.req", dbus_req, 32'd0);
      check("mis_lw.wb_wreg", wb_wreg, 32'd0);
      set_idle();
      tick();
      check("mis_lw.pulse_end", mem_misalign, 32'd0);
      check("mis_lw.req_after", dbus_req, 32'd0);

      present(4'd3, 32'h101, 32'd0, 5'd4, 32'd0, 1'b1);
      #1 check("mis_lh.stall", stall_req, 32'd0);
      tick();
      check("mis_lh.pulse", mem_misalign, 32'd1);
      set_idle();

      // Opcode 9 behaves as no memory op; a stray ack outside REQ is ignored
      present(4'd9, 32'h4, 32'd0, 5'd3, 32'h0000_0055, 1'b1);
      dbus_ack = 1'b1;
      #1 check("op9.stall", stall_req, 32'd0);
      tick();
      check("op9.wb_wd", wb_wd, 32'd3);
      check("op9.wb_wdata", wb_wdata, 32'h0000_0055);
      check("op9.req", dbus_req, 32'd0);
      set_idle();

      // Reset in the middle of a transfer
      present(4'd5, 32'h40, 32'd0, 5'd8, 32'd0, 1'b1);
      tick();
      check("rstmid.req_before", dbus_req, 32'd1);
      tick();
      rst = 1'b1;
      tick();
      check("rstmid.req", dbus_req, 32'd0);
      check("rstmid.stall", stall_req, 32'd0);
      check("rstmid.wb_wreg", wb_wreg, 32'd0);
      check("rstmid.wb_wdata", wb_wdata, 32'd0);
      rst = 1'b0;
      set_idle();
      tick();
      run_mem("after_rst", 4'd5, 32'h44, 32'd0, 32'h0BAD_F00D, 1, 4'b1111, 1'b0, 32'd0);
      check("after_rst.wb_wdata", wb_wdata, 32'h0BAD_F00D);
      set_idle();

      // Load that is never acknowledged
      present(4'd5, 32'h80, 32'd0, 5'd9, 32'd0, 1'b1);
      tick();
      n = 0;
`ifdef DBUS_TIMEOUT_EN
      while (dbus_req && n < 20) begin
         n++;
         tick();
      end
      check("to.req_cycles", n, 32'd4);
      check("to.pulse", dbus_timeout, 32'd1);
      check("to.stall", stall_req, 32'd0);
      tick();
      check("to.pulse_end", dbus_timeout, 32'd0);
      check("to.wb_wreg", wb_wreg, 32'd0);
      set_idle();
`else
      while (dbus_req && n < 120) begin
         n++;
         tick();
         if (dbus_timeout) check("noto.pulse", dbus_timeout, 32'd0);
      end
      check("noto.req_cycles", n, 32'd120);
      check("noto.stall", stall_req, 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      set_idle();
      check("noto.req_after_rst", dbus_req, 32'd0);
`endif
      tick();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- MIPS memory-access stage, consumer end of the EX/MEM pipeline register.
- Takes the EX/MEM outputs (destination, ALU result, write-enable) plus a memory op, address and store data.
- Runs loads and stores on a req/ack data bus through a small FSM, stalling the pipeline while a transfer is outstanding.
- Registers the result toward writeback, so it also acts as the MEM/WB register.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles without ack before abort. Used only with DBUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- mem_wd  in  5  destination register address
- mem_wdata  in  32  ALU result; writeback data for non-load ops
- mem_wreg  in  1  register write enable
- mem_op  in  4  op code: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9-15 treated as none
- mem_addr  in  32  effective address
- mem_sdata  in  32  store data
- dbus_req  out  1  bus request, registered
- dbus_we  out  1  bus write, registered
- dbus_addr  out  32  word address {addr[31:2],2'b00}, registered
- dbus_sel  out  4  byte lane enables, registered
- dbus_wdata  out  32  store data, registered
- dbus_rdata  in  32  read data, valid with ack
- dbus_ack  in  1  transfer complete, single-cycle
- wb_wd  out  5  writeback address
- wb_wdata  out  32  writeback data
- wb_wreg  out  1  writeback enable
- stall_req  out  1  hold EX/MEM and earlier stages (combinational)
- mem_misalign  out  1  one-cycle pulse on a misaligned access
- dbus_timeout  out  1  one-cycle pulse on a bus abort

Behaviour:
- Reset (rst=1 at a clk edge):
  - state goes to IDLE;
  - all outputs go to 0 (dbus_*, wb_*, pulses);
  - timeout counter clears.
  - Applies mid-transfer too: dbus_req drops at the same edge and the in-flight op is discarded.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - Non-memory op: wb_* <= mem_* at the next edge (1-cycle latency); stall_req=0.
  - Misaligned op: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0. No bus cycle; wb_wreg<=0; mem_misalign pulses next cycle; stall_req=0.
  - Aligned memory op: stall_req=1; go to REQ; bus outputs loaded at that edge; wb_* bubble (all 0).
- REQ:
  - dbus_req=1; dbus_addr, sel, we and wdata held stable; stall_req=1; wb_* bubble each cycle.
  - On dbus_ack=1: capture dbus_rdata into an internal register, drop dbus_req at the edge, go to DONE.
- DONE:
  - stall_req=0, so the pipeline advances at this edge.
  - Loads: wb_wd<=mem_wd, wb_wreg<=mem_wreg, wb_wdata<=extended load data.
  - Stores: wb_wreg<=0.
  - Next state is IDLE.
  - Minimum memory-op occupancy is 3 cycles: detect, ack in REQ, DONE.
- Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24.
  - Byte access: sel = 1000 >> addr[1:0].
  - Halfword: sel = 1100 when addr[1]=0, else 0011.
  - Word: sel = 1111.
  - dbus_we=1 for SB/SH/SW, 0 for loads.
- Store data: SB drives {4{sdata[7:0]}}; SH drives {2{sdata[15:0]}}; SW drives sdata.
- Load extension: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- dbus_ack is ignored outside REQ.
- Inputs are held stable by upstream while stall_req=1.

Optional Feature:
- Macro: DBUS_TIMEOUT_EN.
- Defined:
  - The counter increments each REQ cycle without ack.
  - When it reaches TIMEOUT_CYCLES: dbus_req drops, dbus_timeout pulses, state goes to DONE with wb_wreg=0.
  - An ack in the same cycle as the limit wins: normal completion.
- Undefined: REQ waits indefinitely; dbus_timeout is tied to 0.

Test Plan:
- ADD result: op=0, wd=5, wdata=0x1234, wreg=1 -> next cycle wb=(5, 0x1234, 1), stall_req never asserts.
- LB at addr 0x103, ack 2 cycles after req, rdata=0x000000F0 -> sel=0001, stall for 3 cycles plus detect, then wb_wdata=0xFFFFFFF0; LBU at the same address -> 0x000000F0.
- SH at addr 0x202, sdata=0xABCD -> dbus_we=1, addr=0x200, sel=0011, wdata=0xABCDABCD; wb_wreg=0 in DONE.
- LW at addr 0x5 -> no dbus_req, mem_misalign pulses once, wb_wreg=0, stall_req=0.
- Reset mid-transfer: rst during REQ -> dbus_req=0, stall_req=0 and all wb_* = 0 after the edge; a later op proceeds normally.
- With DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, LW with no ack -> req drops after 4 REQ cycles, dbus_timeout pulses, wb_wreg=0; without the macro req stays high for 100+ cycles.
